// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester command path: sequencer state encoding and default widths.
package apb_pkg;

  localparam int unsigned APB_ADD_WIDTH = 9;
  localparam int unsigned APB_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO: 1-cycle push-to-visible, head held until popped; exposes head and head+1.
// Ready is registered and drops while full; a same-cycle pop does not open a slot for a push.
module apb_cmd_fifo #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [W-1:0]  next_dat_o,
  output logic [AW:0]   level_o,
  output logic          rdy_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] nxt_ptr;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          rdy_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & rdy_q;
  assign do_pop  = pop_i & (level_q != '0);
  assign nxt_ptr = rd_ptr_q + 1'b1;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Ready is computed from the next level so it is exact from the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      rdy_q   <= (level_d != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign next_dat_o = mem_q[nxt_ptr];
  assign level_o    = level_q;
  assign rdy_o      = rdy_q;
  assign empty_o    = (level_q == '0);

endmodule

// File: rtl/apb_req_sequencer.sv
// Queues commands and issues them one at a time to the APB requester, returning one response each.
// Push to response >= 4 cycles; cmd_ready drops when the queue is full, responses hold until rsp_ready.
module apb_req_sequencer
  import apb_pkg::*;
#(
  parameter int unsigned ADD_WIDTH = APB_ADD_WIDTH,
  parameter int unsigned WIDTH     = APB_WIDTH,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [WIDTH/8-1:0]      cmd_strb,
  input  logic [ADD_WIDTH-1:0]    cmd_addr,
  input  logic [WIDTH-1:0]        cmd_wdata,
  output logic                    transfer,
  output logic                    Req_read_write,
  output logic [WIDTH/8-1:0]      Req_pstrb,
  output logic [ADD_WIDTH-1:0]    Req_addr,
  output logic [WIDTH-1:0]        Req_wdata,
  input  logic [WIDTH-1:0]        Req_rdata,
  input  logic                    apb_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [WIDTH-1:0]        rsp_rdata,
  output logic                    rsp_err,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int unsigned SW = WIDTH / 8;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                 wr;
    logic [SW-1:0]        strb;
    logic [ADD_WIDTH-1:0] addr;
    logic [WIDTH-1:0]     wdata;
  } cmd_t;

  cmd_t          push_cmd;
  cmd_t          head_cmd;
  cmd_t          next_cmd;
  cmd_t          req_q;
  cmd_t          req_d;
  apb_state_e    state_q;
  apb_state_e    state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          transfer_q;
  logic          rsp_valid_q;
  logic          rsp_write_q;
  logic          rsp_write_d;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic [WIDTH-1:0] rsp_rdata_d;
  logic          rsp_err_q;
  logic          rsp_err_d;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [LW-1:0] level;

  assign push_cmd = '{wr: cmd_write, strb: cmd_strb, addr: cmd_addr, wdata: cmd_wdata};

  apb_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (pclk),
    .rst_n      (presetn),
    .push_i     (cmd_valid),
    .push_dat_i (push_cmd),
    .pop_i      (fifo_pop),
    .head_dat_o (head_cmd),
    .next_dat_o (next_cmd),
    .level_o    (level),
    .rdy_o      (cmd_ready),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    req_d       = req_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_ISSUE;
          req_d   = head_cmd;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        // Completion is checked first so a done in the last timeout cycle is not an error.
        if (apb_done) begin
          state_d     = ST_RESP;
          rsp_write_d = req_q.wr;
          rsp_rdata_d = req_q.wr ? '0 : Req_rdata;
          rsp_err_d   = 1'b0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          rsp_write_d = req_q.wr;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          fifo_pop = 1'b1;
          // The head is still occupied here, so the following command sits one slot behind it.
          if (level > LW'(1)) begin
            state_d = ST_ISSUE;
            req_d   = next_cmd;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      req_q       <= '0;
      transfer_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
      transfer_q  <= (state_d == ST_ISSUE);
      rsp_valid_q <= (state_d == ST_RESP);
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign transfer       = transfer_q;
  assign Req_read_write = req_q.wr;
  assign Req_pstrb      = req_q.strb;
  assign Req_addr       = req_q.addr;
  assign Req_wdata      = req_q.wdata;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign fifo_level     = level;

endmodule
